load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the execute stage and the word-addressed data memory.
- Accepts one load/store request at a time and converts byte, halfword and word accesses into word address, byte-enable and replicated write data.
- Drives the memory read strobe and captures the memory's registered read data one cycle later. Extracts and sign- or zero-extends the loaded value.
- Reports misaligned, out-of-range and illegal-funct3 faults without touching memory.

Parameters:
- SIZE, 4096: data memory size in bytes. Byte addresses at or above SIZE are out of range.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE (combinational from state).
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rd  in  5  destination register tag, returned unchanged.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_rd  out  5  tag of the completed request.
- resp_misaligned  out  1  address not aligned to the access size.
- resp_fault  out  1  out of range or illegal funct3.
- mem_read_ready  out  1  memory read strobe.
- mem_ok_read  out  1  memory read qualifier; always equal to mem_read_ready.
- mem_read_address  out  [31:2]  word read address.
- mem_read_data  in  32  memory read data, registered by memory.
- mem_write_ready  out  1  memory write strobe.
- mem_write_address  out  [31:2]  word write address.
- mem_write_data  out  32  lane-replicated store data.
- mem_write_byte  out  4  byte enables.

Behaviour:
- Reset:
  - state goes to IDLE.
  - All registered outputs go to 0: resp_*, mem_* strobes, addresses, data and byte enables.
  - Reset mid-operation abandons the request: no strobe the following cycle and no response.
- States:
  - IDLE: req_ready=1. On req_valid, latch the request and decode it.
    - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): go to RESP, resp_misaligned=1.
    - Else illegal funct3 (load 011/110/111; store 011-111) or addr>=SIZE: go to RESP, resp_fault=1.
    - Misaligned takes priority over fault.
    - Otherwise go to ISSUE.
  - ISSUE: memory outputs are registered and asserted for exactly this one cycle.
    - Store: mem_write_ready=1, then go to RESP.
    - Load: mem_read_ready=mem_ok_read=1, mem_read_address=addr[31:2], then go to WAIT.
  - WAIT: mem_read_data is valid. Shift right by 8*addr[1:0], then:
    - LB: sign-extend bit 7.
    - LBU: zero-extend bit 7.
    - LH: sign-extend bit 15.
    - LHU: zero-extend bit 15.
    - LW: pass through.
    - Register the result into resp_rdata, then go to RESP.
  - RESP: resp_valid=1 with resp_rd and the flags for one cycle, then IDLE. Response outputs return to 0 on the next cycle.
- Store formatting:
  - SB: byte enables 0001<<addr[1:0], data {4{wdata[7:0]}}.
  - SH: byte enables 0011<<addr[1:0], data {2{wdata[15:0]}}.
  - SW: byte enables 1111, data = wdata.
- Latency from the accept edge:
  - Load: resp_valid 3 cycles later.
  - Store: resp_valid 2 cycles later.
  - Fault: resp_valid 1 cycle later.
- Throughput:
  - Next accept is possible in the cycle after RESP.
  - req_valid outside IDLE is ignored and not latched.
- A write and a read are never issued in the same cycle, so the memory's same-address forwarding path is unused.

Test Plan:
- Memory word 0x100=0x8034F2A1:
  - LB @0x101 -> 0xFFFFFFF2.
  - LBU @0x103 -> 0x00000080.
  - LH @0x102 -> 0xFFFF8034.
  - LHU @0x100 -> 0x0000F2A1.
  - Each has resp_valid exactly 3 cycles after accept.
- SB wdata 0x1234565A @0x102 -> during ISSUE: mem_write_byte=0100, mem_write_data=0x5A5A5A5A, mem_write_address=0x40. A following LW @0x100 -> 0x805AF2A1.
- Misaligned cases:
  - LW @0x102 -> resp_misaligned=1 one cycle after accept, no mem strobes.
  - SH @0x101 -> resp_misaligned=1 one cycle after accept, no mem strobes.
- Fault cases, both with resp_fault=1 and no strobes:
  - LW @0x1000 (SIZE=4096).
  - Load funct3=011.
- Reset asserted during WAIT -> next cycle IDLE, req_ready=1, resp_valid never pulses. A subsequent LW @0x100 completes normally.
- req_valid held high continuously with alternating store/load -> accepts occur only in IDLE, exactly one resp_valid per accepted request, resp_rd tags in order.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response port towards the execute stage and the word-addressed data memory port
// of the load/store unit. slave is the unit's view, master the surrounding pipeline/memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_misaligned;
  logic        resp_fault;

  logic        mem_read_ready;
  logic        mem_ok_read;
  logic [31:2] mem_read_address;
  logic [31:0] mem_read_data;
  logic        mem_write_ready;
  logic [31:2] mem_write_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_byte;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_read_data,
    output req_ready,
    output resp_valid, resp_rdata, resp_rd, resp_misaligned, resp_fault,
    output mem_read_ready, mem_ok_read, mem_read_address,
    output mem_write_ready, mem_write_address, mem_write_data, mem_write_byte
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, req_rd,
    output mem_read_data,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_rd, resp_misaligned, resp_fault,
    input  mem_read_ready, mem_ok_read, mem_read_address,
    input  mem_write_ready, mem_write_address, mem_write_data, mem_write_byte
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte/half/word formatting towards a word-addressed
// memory with registered read data, load extension, and misalignment/fault reporting.
module load_store_unit #(
  parameter int unsigned SIZE = 4096
) (
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus
);
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned WAW = 30;
  localparam int unsigned RW  = 5;
  localparam int unsigned BEW = 4;
  localparam logic [AW-1:0] SIZE_LIMIT = AW'(SIZE);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_d;

  logic          lat_write,  lat_write_d;
  logic [2:0]    lat_funct3, lat_funct3_d;
  logic [1:0]    lat_off,    lat_off_d;
  logic [RW-1:0] lat_rd,     lat_rd_d;

  logic           resp_valid_q,      resp_valid_d;
  logic [DW-1:0]  resp_rdata_q,      resp_rdata_d;
  logic [RW-1:0]  resp_rd_q,         resp_rd_d;
  logic           resp_misaligned_q, resp_misaligned_d;
  logic           resp_fault_q,      resp_fault_d;
  logic           mem_rd_q,          mem_rd_d;
  logic [WAW-1:0] mem_raddr_q,       mem_raddr_d;
  logic           mem_wr_q,          mem_wr_d;
  logic [WAW-1:0] mem_waddr_q,       mem_waddr_d;
  logic [DW-1:0]  mem_wdata_q,       mem_wdata_d;
  logic [BEW-1:0] mem_be_q,          mem_be_d;

  // Request decode: alignment, legality, range and store lane formatting
  logic           dec_half;
  logic           dec_word;
  logic           dec_legal;
  logic           dec_misaligned;
  logic           dec_fault;
  logic [BEW-1:0] dec_be;
  logic [DW-1:0]  dec_wdata;

  always_comb begin
    dec_half  = (bus.req_funct3 == F3_H) || (!bus.req_write && (bus.req_funct3 == F3_HU));
    dec_word  = (bus.req_funct3 == F3_W);
    if (bus.req_write) begin
      dec_legal = (bus.req_funct3 == F3_B) || (bus.req_funct3 == F3_H) || (bus.req_funct3 == F3_W);
    end else begin
      dec_legal = (bus.req_funct3 == F3_B)  || (bus.req_funct3 == F3_H)  ||
                  (bus.req_funct3 == F3_W)  || (bus.req_funct3 == F3_BU) ||
                  (bus.req_funct3 == F3_HU);
    end
    dec_misaligned = (dec_half && bus.req_addr[0]) ||
                     (dec_word && (bus.req_addr[1:0] != 2'b00));
    dec_fault      = !dec_legal || (bus.req_addr >= SIZE_LIMIT);

    case (bus.req_funct3[1:0])
      2'b00: begin
        dec_be    = BEW'(4'b0001 << bus.req_addr[1:0]);
        dec_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        dec_be    = BEW'(4'b0011 << bus.req_addr[1:0]);
        dec_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        dec_be    = 4'b1111;
        dec_wdata = bus.req_wdata;
      end
    endcase
  end

  // Load data alignment and sign/zero extension of the registered memory word
  logic [DW-1:0] ld_shifted;
  logic [DW-1:0] ld_value;

  always_comb begin
    ld_shifted = bus.mem_read_data >> {lat_off, 3'b000};
    case (lat_funct3)
      F3_B:    ld_value = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      F3_BU:   ld_value = {24'd0, ld_shifted[7:0]};
      F3_H:    ld_value = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_HU:   ld_value = {16'd0, ld_shifted[15:0]};
      default: ld_value = ld_shifted;
    endcase
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d           = state;
    lat_write_d       = lat_write;
    lat_funct3_d      = lat_funct3;
    lat_off_d         = lat_off;
    lat_rd_d          = lat_rd;
    resp_valid_d      = 1'b0;
    resp_rdata_d      = '0;
    resp_rd_d         = '0;
    resp_misaligned_d = 1'b0;
    resp_fault_d      = 1'b0;
    mem_rd_d          = 1'b0;
    mem_raddr_d       = '0;
    mem_wr_d          = 1'b0;
    mem_waddr_d       = '0;
    mem_wdata_d       = '0;
    mem_be_d          = '0;

    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          lat_write_d  = bus.req_write;
          lat_funct3_d = bus.req_funct3;
          lat_off_d    = bus.req_addr[1:0];
          lat_rd_d     = bus.req_rd;
          if (dec_misaligned) begin
            state_d           = S_RESP;
            resp_valid_d      = 1'b1;
            resp_rd_d         = bus.req_rd;
            resp_misaligned_d = 1'b1;
          end else if (dec_fault) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rd_d    = bus.req_rd;
            resp_fault_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
            if (bus.req_write) begin
              mem_wr_d    = 1'b1;
              mem_waddr_d = bus.req_addr[31:2];
              mem_wdata_d = dec_wdata;
              mem_be_d    = dec_be;
            end else begin
              mem_rd_d    = 1'b1;
              mem_raddr_d = bus.req_addr[31:2];
            end
          end
        end
      end
      S_ISSUE: begin
        if (lat_write) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rd_d    = lat_rd;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rd_d    = lat_rd;
        resp_rdata_d = ld_value;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      lat_write         <= 1'b0;
      lat_funct3        <= '0;
      lat_off           <= '0;
      lat_rd            <= '0;
      resp_valid_q      <= 1'b0;
      resp_rdata_q      <= '0;
      resp_rd_q         <= '0;
      resp_misaligned_q <= 1'b0;
      resp_fault_q      <= 1'b0;
      mem_rd_q          <= 1'b0;
      mem_raddr_q       <= '0;
      mem_wr_q          <= 1'b0;
      mem_waddr_q       <= '0;
      mem_wdata_q       <= '0;
      mem_be_q          <= '0;
    end else begin
      state             <= state_d;
      lat_write         <= lat_write_d;
      lat_funct3        <= lat_funct3_d;
      lat_off           <= lat_off_d;
      lat_rd            <= lat_rd_d;
      resp_valid_q      <= resp_valid_d;
      resp_rdata_q      <= resp_rdata_d;
      resp_rd_q         <= resp_rd_d;
      resp_misaligned_q <= resp_misaligned_d;
      resp_fault_q      <= resp_fault_d;
      mem_rd_q          <= mem_rd_d;
      mem_raddr_q       <= mem_raddr_d;
      mem_wr_q          <= mem_wr_d;
      mem_waddr_q       <= mem_waddr_d;
      mem_wdata_q       <= mem_wdata_d;
      mem_be_q          <= mem_be_d;
    end
  end

  assign bus.req_ready         = (state == S_IDLE);
  assign bus.resp_valid        = resp_valid_q;
  assign bus.resp_rdata        = resp_rdata_q;
  assign bus.resp_rd           = resp_rd_q;
  assign bus.resp_misaligned   = resp_misaligned_q;
  assign bus.resp_fault        = resp_fault_q;
  assign bus.mem_read_ready    = mem_rd_q;
  assign bus.mem_ok_read       = mem_rd_q;
  assign bus.mem_read_address  = mem_raddr_q;
  assign bus.mem_write_ready   = mem_wr_q;
  assign bus.mem_write_address = mem_waddr_q;
  assign bus.mem_write_data    = mem_wdata_q;
  assign bus.mem_write_byte    = mem_be_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural byte-array model checked every cycle, plus directed
// transactions with hand-computed expectations.
module tb_load_store_unit;
  localparam int unsigned SIZE  = 4096;
  localparam int unsigned WORDS = SIZE / 4;
  localparam int unsigned NOPS  = 9;

  typedef struct packed {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [4:0]  rd;
  } op_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  load_store_unit_if bus ();
  load_store_unit #(.SIZE(SIZE)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 64) return 32'h8034_F2A1;
    return (32'(i) * 32'h0100_0193) ^ 32'h5A3C_0F00;
  endfunction

  // Word memory with byte enables and one-cycle registered read data
  logic [31:0] memw [WORDS];
  logic        mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < int'(WORDS); i++) memw[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else begin
      if (bus.mem_write_ready)
        for (int b = 0; b < 4; b++)
          if (bus.mem_write_byte[b])
            memw[bus.mem_write_address[11:2]][8*b +: 8] <= bus.mem_write_data[8*b +: 8];
      if (bus.mem_read_ready) bus.mem_read_data <= memw[bus.mem_read_address[11:2]];
    end
  end

  // Reference model: byte array plus expected outputs for the cycle after each edge
  logic [7:0]  refm [SIZE];
  logic        ref_loaded = 1'b0;
  logic        model_ok   = 1'b0;
  logic        e_ready, e_rv, e_mis, e_flt, e_wr, e_rs;
  logic [4:0]  e_rd;
  logic [31:0] e_rdata, e_wdata;
  logic [29:0] e_waddr, e_raddr;
  logic [3:0]  e_be;
  logic        p_act;
  int          p_cnt;
  logic [4:0]  p_rd;
  logic [31:0] p_rdata;
  logic        p_mis, p_flt;

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = refm[a[11:0]];
    b1 = refm[a[11:0] + 12'd1];
    b2 = refm[a[11:0] + 12'd2];
    b3 = refm[a[11:0] + 12'd3];
    case (f3)
      3'b000:  return 32'($signed(b0));
      3'b100:  return {24'd0, b0};
      3'b001:  return 32'($signed({b1, b0}));
      3'b101:  return {16'd0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  initial begin
    logic        w, legal, mis, flt;
    logic [2:0]  f3;
    logic [1:0]  sz;
    logic [31:0] a, wd, word;
    int          lat;
    forever begin
      @(posedge clk);
      e_rv = 1'b0; e_rd = '0; e_rdata = '0; e_mis = 1'b0; e_flt = 1'b0;
      e_wr = 1'b0; e_rs = 1'b0; e_waddr = '0; e_raddr = '0; e_wdata = '0; e_be = '0;
      if (reset) begin
        if (!ref_loaded) begin
          for (int i = 0; i < int'(WORDS); i++) begin
            word = init_word(i);
            for (int b = 0; b < 4; b++) refm[4*i + b] = word[8*b +: 8];
          end
          ref_loaded = 1'b1;
        end
        model_ok = 1'b1;
        p_act    = 1'b0;
        e_ready  = 1'b1;
      end else begin
        if (!p_act && e_ready && bus.req_valid) begin
          w  = bus.req_write; f3 = bus.req_funct3; a = bus.req_addr; wd = bus.req_wdata;
          sz = f3[1:0];
          legal = w ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
          mis   = legal && ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0));
          flt   = !mis && (!legal || a >= SIZE);
          p_mis = mis; p_flt = flt; p_rd = bus.req_rd; p_rdata = '0;
          lat   = 1;
          if (!mis && !flt) begin
            if (w) begin
              lat = 2; e_wr = 1'b1; e_waddr = a[31:2];
              case (sz)
                2'd0: begin
                  e_be = 4'(1 << a[1:0]); e_wdata = {4{wd[7:0]}};
                  refm[a[11:0]] = wd[7:0];
                end
                2'd1: begin
                  e_be = 4'(3 << a[1:0]); e_wdata = {2{wd[15:0]}};
                  refm[a[11:0]] = wd[7:0]; refm[a[11:0] + 12'd1] = wd[15:8];
                end
                default: begin
                  e_be = 4'hF; e_wdata = wd;
                  for (int b = 0; b < 4; b++) refm[a[11:0] + 12'(b)] = wd[8*b +: 8];
                end
              endcase
            end else begin
              lat = 3; e_rs = 1'b1; e_raddr = a[31:2];
              p_rdata = load_value(f3, a);
            end
          end
          p_act = 1'b1; p_cnt = lat; e_ready = 1'b0;
        end else if (!p_act) begin
          e_ready = 1'b1;
        end
        if (p_act) begin
          p_cnt--;
          if (p_cnt == 0) begin
            e_rv = 1'b1; e_rd = p_rd; e_rdata = p_rdata; e_mis = p_mis; e_flt = p_flt;
            p_act = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("req_ready",       32'(bus.req_ready),       32'(e_ready));
        check("resp_valid",      32'(bus.resp_valid),      32'(e_rv));
        check("resp_rd",         32'(bus.resp_rd),         32'(e_rd));
        check("resp_rdata",      bus.resp_rdata,           e_rdata);
        check("resp_misaligned", 32'(bus.resp_misaligned), 32'(e_mis));
        check("resp_fault",      32'(bus.resp_fault),      32'(e_flt));
        check("mem_write_ready", 32'(bus.mem_write_ready), 32'(e_wr));
        check("mem_read_ready",  32'(bus.mem_read_ready),  32'(e_rs));
        check("mem_ok_read",     32'(bus.mem_ok_read),     32'(e_rs));
        if (e_wr) begin
          check("mem_write_address", 32'(bus.mem_write_address), 32'(e_waddr));
          check("mem_write_data",    bus.mem_write_data,          e_wdata);
          check("mem_write_byte",    32'(bus.mem_write_byte),     32'(e_be));
        end
        if (e_rs) check("mem_read_address", 32'(bus.mem_read_address), 32'(e_raddr));
      end
    end
  end

  // Observers used by the directed checks
  int          n_strobe = 0;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic [29:0] cap_waddr;
  logic [4:0]  rdq [$];

  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_write_ready || bus.mem_read_ready) n_strobe++;
      if (bus.mem_write_ready) begin
        cap_be = bus.mem_write_byte; cap_wdata = bus.mem_write_data; cap_waddr = bus.mem_write_address;
      end
      if (bus.resp_valid) rdq.push_back(bus.resp_rd);
    end
  end

  task automatic drive(input op_t o);
    bus.req_write  = o.w;
    bus.req_funct3 = o.f3;
    bus.req_addr   = o.a;
    bus.req_wdata  = o.wd;
    bus.req_rd     = o.rd;
  endtask

  // One request; returns response fields and latency in cycles after the accept edge
  task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd,
                        output logic [31:0] rdata, output int lat, output logic mis, output logic flt);
    int g;
    @(negedge clk);
    drive('{w, f3, a, wd, rd});
    bus.req_valid = 1'b1;
    g = 0;
    while (!bus.req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) check("accept_timeout", 32'(g), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rdata = bus.resp_rdata;
    mis   = bus.resp_misaligned;
    flt   = bus.resp_fault;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv;
    int          lat, s0, idx;
    logic        mis, flt, acc, seen;
    op_t         ops [NOPS];

    reset = 1'b1;
    bus.req_valid = 1'b0;
    drive('{1'b0, 3'b000, 32'd0, 32'd0, 5'd0});
    repeat (3) @(negedge clk);
    check("rst_req_ready",  32'(bus.req_ready),       32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid),      32'd0);
    check("rst_strobes",    32'(bus.mem_write_ready || bus.mem_read_ready), 32'd0);
    reset = 1'b0;

    run_op(1'b0, 3'b000, 32'h101, 32'd0, 5'd1, rv, lat, mis, flt);
    check("lb_data", rv, 32'hFFFF_FFF2);   check("lb_lat", 32'(lat), 32'd3);
    run_op(1'b0, 3'b100, 32'h103, 32'd0, 5'd2, rv, lat, mis, flt);
    check("lbu_data", rv, 32'h0000_0080);  check("lbu_lat", 32'(lat), 32'd3);
    run_op(1'b0, 3'b001, 32'h102, 32'd0, 5'd3, rv, lat, mis, flt);
    check("lh_data", rv, 32'hFFFF_8034);   check("lh_lat", 32'(lat), 32'd3);
    run_op(1'b0, 3'b101, 32'h100, 32'd0, 5'd4, rv, lat, mis, flt);
    check("lhu_data", rv, 32'h0000_F2A1);  check("lhu_lat", 32'(lat), 32'd3);

    s0 = n_strobe;
    run_op(1'b1, 3'b000, 32'h102, 32'h1234_565A, 5'd5, rv, lat, mis, flt);
    check("sb_lat", 32'(lat), 32'd2);
    check("sb_be", 32'(cap_be), 32'h4);
    check("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
    check("sb_waddr", 32'(cap_waddr), 32'h40);
    check("sb_strobes", 32'(n_strobe - s0), 32'd1);
    check("sb_rdata", rv, 32'd0);
    run_op(1'b0, 3'b010, 32'h100, 32'd0, 5'd6, rv, lat, mis, flt);
    check("lw_after_sb", rv, 32'h805A_F2A1);

    s0 = n_strobe;
    run_op(1'b0, 3'b010, 32'h102, 32'd0, 5'd7, rv, lat, mis, flt);
    check("lw_mis_flag", 32'(mis), 32'd1); check("lw_mis_fault", 32'(flt), 32'd0);
    check("lw_mis_lat", 32'(lat), 32'd1);
    run_op(1'b1, 3'b001, 32'h101, 32'hFFFF, 5'd8, rv, lat, mis, flt);
    check("sh_mis_flag", 32'(mis), 32'd1); check("sh_mis_lat", 32'(lat), 32'd1);
    run_op(1'b0, 3'b010, 32'h1000, 32'd0, 5'd9, rv, lat, mis, flt);
    check("oor_fault", 32'(flt), 32'd1);   check("oor_mis", 32'(mis), 32'd0);
    check("oor_lat", 32'(lat), 32'd1);
    run_op(1'b0, 3'b011, 32'h100, 32'd0, 5'd10, rv, lat, mis, flt);
    check("f3_fault", 32'(flt), 32'd1);    check("f3_lat", 32'(lat), 32'd1);
    check("fault_strobes", 32'(n_strobe - s0), 32'd0);

    // Reset while the load waits for memory data
    @(negedge clk);
    drive('{1'b0, 3'b010, 32'h100, 32'd0, 5'd11});
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_wait_ready", 32'(bus.req_ready), 32'd1);
    seen = bus.resp_valid;
    repeat (5) begin
      @(negedge clk);
      seen = seen | bus.resp_valid;
    end
    check("rst_wait_no_resp", 32'(seen), 32'd0);
    run_op(1'b0, 3'b010, 32'h100, 32'd0, 5'd12, rv, lat, mis, flt);
    check("lw_post_rst", rv, 32'h805A_F2A1); check("lw_post_rst_lat", 32'(lat), 32'd3);

    // Back-to-back requests with req_valid held high
    ops[0] = '{1'b1, 3'b010, 32'h200, 32'hCAFE_BABE, 5'd1};
    ops[1] = '{1'b0, 3'b010, 32'h200, 32'd0,         5'd2};
    ops[2] = '{1'b1, 3'b001, 32'h206, 32'h1234_BEEF, 5'd3};
    ops[3] = '{1'b0, 3'b001, 32'h206, 32'd0,         5'd4};
    ops[4] = '{1'b1, 3'b000, 32'h209, 32'h0000_00F7, 5'd5};
    ops[5] = '{1'b0, 3'b000, 32'h209, 32'd0,         5'd6};
    ops[6] = '{1'b1, 3'b000, 32'h2000, 32'h55,       5'd7};
    ops[7] = '{1'b1, 3'b100, 32'h210, 32'h66,        5'd8};
    ops[8] = '{1'b0, 3'b101, 32'h204, 32'd0,         5'd9};
    rdq.delete();
    @(negedge clk);
    drive(ops[0]);
    bus.req_valid = 1'b1;
    idx = 0;
    for (int g = 0; g < 300 && idx < int'(NOPS); g++) begin
      acc = bus.req_ready;
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < int'(NOPS)) drive(ops[idx]);
      end
    end
    bus.req_valid = 1'b0;
    check("stream_accepts", 32'(idx), 32'(NOPS));
    repeat (6) @(negedge clk);
    check("stream_resp_count", 32'(rdq.size()), 32'(NOPS));
    for (int k = 0; k < int'(NOPS); k++)
      if (k < rdq.size()) check("stream_tag_order", 32'(rdq[k]), 32'(k + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
